// File: rtl/alu_pkg.sv
// Shared definitions for the UART ALU packet engine: opcodes, header length
// and the parser state encoding.
package alu_pkg;

   localparam logic [7:0]  OP_ECHO = 8'hEC;
   localparam logic [7:0]  OP_ADD  = 8'hAD;
   localparam logic [7:0]  OP_MUL  = 8'h63;
   localparam logic [15:0] HDR_LEN = 16'd4;

   typedef enum logic [2:0] {
      ST_OPCODE,
      ST_RSVD,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_ECHO,
      ST_OPERAND,
      ST_DRAIN,
      ST_RESULT
   } engineState_t;

endpackage

// File: rtl/alu_packet_engine_if.sv
// Byte-level handshake bundle between the UART RX/TX blocks and the packet
// engine. The engine sits on the slave side; the UART glue (or a bench) is
// the master.
interface alu_packet_engine_if;

   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic       rx_ready_o;
   logic [7:0] tx_data_o;
   logic       tx_valid_o;
   logic       tx_ready_i;

   modport slave (
      input  rx_data_i,
      input  rx_valid_i,
      output rx_ready_o,
      output tx_data_o,
      output tx_valid_o,
      input  tx_ready_i
   );

   modport master (
      output rx_data_i,
      output rx_valid_i,
      input  rx_ready_o,
      input  tx_data_o,
      input  tx_valid_o,
      output tx_ready_i
   );

endinterface

// File: rtl/alu_packet_engine.sv
// Packet engine for the UART ALU: parses framed packets from the RX byte
// stream and either echoes the payload or reduces 32-bit little-endian
// operands (add, optionally multiply) into a 4-byte LSB-first result.
// Optional feature macro: ALU_MUL_EN enables opcode 0x63 (multiply); without
// it 0x63 is drained like any unknown opcode and no multiplier exists.
module alu_packet_engine
   import alu_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   alu_packet_engine_if.slave  bus
);

   engineState_t state;
   engineState_t nextState;

   logic [7:0]  opcode;
   logic [7:0]  lenLo;
   logic [15:0] remaining;
   logic [31:0] acc;
   logic [31:0] opShift;
   logic [1:0]  opIdx;
   logic        firstOp;
   logic [1:0]  resIdx;
   logic [7:0]  txData;
   logic        txValid;

   logic        rxReady;
   logic        rxFire;
   logic        txFire;
   logic        lastPayload;
   logic [15:0] lenWord;
   logic [15:0] payloadLen;
   logic        isAddOp;
   logic        isMulOp;
   logic        isReduce;
   logic [31:0] opWord;
   logic [31:0] combined;
   logic [31:0] nextAcc;
   logic [7:0]  nextResByte;

   assign txFire      = txValid && bus.tx_ready_i;
   assign rxFire      = bus.rx_valid_i && rxReady;
   assign lastPayload = rxFire && (remaining == 16'd1);
   assign lenWord     = {bus.rx_data_i, lenLo};
   assign payloadLen  = (lenWord > HDR_LEN) ? (lenWord - HDR_LEN) : 16'd0;
   assign isAddOp     = (opcode == OP_ADD);
`ifdef ALU_MUL_EN
   assign isMulOp     = (opcode == OP_MUL);
`else
   assign isMulOp     = 1'b0;
`endif
   assign isReduce    = isAddOp || isMulOp;
   assign opWord      = {bus.rx_data_i, opShift[31:8]};
   assign nextAcc     = (opIdx == 2'd3) ? combined : acc;

   assign bus.rx_ready_o = rxReady;
   assign bus.tx_data_o  = txData;
   assign bus.tx_valid_o = txValid;

   // The engine takes RX bytes freely while parsing or swallowing payload;
   // in echo it only takes one when the TX holding register has room (empty
   // or emptying this cycle), and it refuses input while sending a result.
   always_comb begin
      rxReady = 1'b0;
      if (!rst_i) begin
         case (state)
            ST_ECHO:   rxReady = !txValid || bus.tx_ready_i;
            ST_RESULT: rxReady = 1'b0;
            default:   rxReady = 1'b1;
         endcase
      end
   end

   // Combine a freshly completed operand with the accumulator. The first
   // operand of a packet simply loads; later ones add or multiply in.
   always_comb begin
      combined = opWord;
      if (!firstOp) begin
`ifdef ALU_MUL_EN
         if (isMulOp) begin
            combined = acc * opWord;
         end else begin
            combined = acc + opWord;
         end
`else
         combined = acc + opWord;
`endif
      end
   end

   // Pick the result byte that follows the one currently on TX.
   always_comb begin
      case (resIdx)
         2'd0:    nextResByte = acc[15:8];
         2'd1:    nextResByte = acc[23:16];
         default: nextResByte = acc[31:24];
      endcase
   end

   // Next-state logic for the packet parser. After the length MSB the
   // opcode decides between echo, operand reduction and draining; an empty
   // payload skips straight to the result (reductions) or back to idle.
   always_comb begin
      nextState = state;
      case (state)
         ST_OPCODE:  if (rxFire) nextState = ST_RSVD;
         ST_RSVD:    if (rxFire) nextState = ST_LEN_LO;
         ST_LEN_LO:  if (rxFire) nextState = ST_LEN_HI;
         ST_LEN_HI: begin
            if (rxFire) begin
               if (payloadLen == 16'd0) begin
                  nextState = isReduce ? ST_RESULT : ST_OPCODE;
               end else if (opcode == OP_ECHO) begin
                  nextState = ST_ECHO;
               end else if (isReduce) begin
                  nextState = ST_OPERAND;
               end else begin
                  nextState = ST_DRAIN;
               end
            end
         end
         ST_ECHO:    if (lastPayload) nextState = ST_OPCODE;
         ST_DRAIN:   if (lastPayload) nextState = ST_OPCODE;
         ST_OPERAND: if (lastPayload) nextState = ST_RESULT;
         ST_RESULT:  if (txFire && (resIdx == 2'd3)) nextState = ST_OPCODE;
         default:    nextState = ST_OPCODE;
      endcase
   end

   // State register; reset drops any packet in flight so the next byte is
   // treated as an opcode.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_OPCODE;
      end else begin
         state <= nextState;
      end
   end

   // Header capture, payload counting and operand assembly. Operand bytes
   // shift in from the top so four LSB-first bytes land as a proper word;
   // leftover bytes short of a full operand never reach the accumulator.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         opcode    <= 8'h00;
         lenLo     <= 8'h00;
         remaining <= 16'd0;
         acc       <= 32'd0;
         opShift   <= 32'd0;
         opIdx     <= 2'd0;
         firstOp   <= 1'b1;
      end else if (rxFire) begin
         case (state)
            ST_OPCODE: opcode <= bus.rx_data_i;
            ST_LEN_LO: lenLo  <= bus.rx_data_i;
            ST_LEN_HI: begin
               remaining <= payloadLen;
               acc       <= 32'd0;
               opIdx     <= 2'd0;
               firstOp   <= 1'b1;
            end
            ST_ECHO, ST_DRAIN: remaining <= remaining - 16'd1;
            ST_OPERAND: begin
               remaining <= remaining - 16'd1;
               opShift   <= opWord;
               opIdx     <= opIdx + 2'd1;
               if (opIdx == 2'd3) begin
                  acc     <= combined;
                  firstOp <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // TX holding register. A transfer empties it unless something new is
   // loaded the same cycle: an echoed byte, the first result byte (taken
   // from the just-updated accumulator value), or the next result byte.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         txData  <= 8'h00;
         txValid <= 1'b0;
         resIdx  <= 2'd0;
      end else begin
         if (txFire) begin
            txValid <= 1'b0;
         end
         case (state)
            ST_ECHO: begin
               if (rxFire) begin
                  txData  <= bus.rx_data_i;
                  txValid <= 1'b1;
               end
            end
            ST_LEN_HI: begin
               if (rxFire && (payloadLen == 16'd0) && isReduce) begin
                  txData  <= 8'h00;
                  txValid <= 1'b1;
                  resIdx  <= 2'd0;
               end
            end
            ST_OPERAND: begin
               if (lastPayload) begin
                  txData  <= nextAcc[7:0];
                  txValid <= 1'b1;
                  resIdx  <= 2'd0;
               end
            end
            ST_RESULT: begin
               if (txFire && (resIdx != 2'd3)) begin
                  txData  <= nextResByte;
                  txValid <= 1'b1;
                  resIdx  <= resIdx + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
